// File: rtl/log_lut_arbiter_if.sv
// ----------------------------------------------------------------------------
// log_lut_arbiter_if
// Request and response channels between the datapath lanes and the shared
// log_lut arbiter.
//
// Parameters:
//   NUM_REQ  number of requesters
//   DATA_W   operand/result width
//   ID_W     requester index width
//
// Signals:
//   req_valid  [NUM_REQ]         per-requester operand valid
//   req_data   [NUM_REQ*DATA_W]  operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready  [NUM_REQ]         one-hot accept from the arbiter
//   resp_valid                   result available
//   resp_ready                   downstream accepts result
//   resp_data  [DATA_W]          registered LUT result
//   resp_id    [ID_W]            requester that owns resp_data
//
// Modports:
//   master  requester/consumer side (drives requests, accepts responses)
//   slave   arbiter side
// ----------------------------------------------------------------------------
interface log_lut_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) ();
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [DATA_W-1:0]         resp_data;
    logic [ID_W-1:0]           resp_id;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/log_lut_arbiter.sv
// ----------------------------------------------------------------------------
// log_lut_arbiter
// Round-robin arbiter and sequencer sharing one combinational log_lut among
// NUM_REQ requesters. One operand is accepted at a time and driven onto the
// LUT input. The block waits LUT_LAT settle cycles, then registers the LUT
// output and returns it with the requester ID.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   DATA_W   operand/result width
//   LUT_LAT  settle cycles spent in LOOKUP (1..15)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   bus        slave modport of log_lut_arbiter_if (request/response channels)
//   lut_in     out  registered operand to log_lut d_in
//   lut_out    in   log_lut d_out
//   busy       out  high in any state other than IDLE
//   stat_done  out  saturating count of response handshakes (optional)
//   stat_stall out  saturating count of RESP cycles with resp_ready low (optional)
//
// Optional feature macro: LOG_LUT_ARBITER_STATS_EN adds stat_done/stat_stall.
// ----------------------------------------------------------------------------
module log_lut_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int LUT_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    log_lut_arbiter_if.slave   bus,
    output logic [DATA_W-1:0]  lut_in,
    input  logic [DATA_W-1:0]  lut_out,
    output logic               busy
`ifdef LOG_LUT_ARBITER_STATS_EN
    ,
    output logic [31:0]        stat_done,
    output logic [31:0]        stat_stall
`endif
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [3:0]          cnt;
    logic [ID_W-1:0]     resp_id_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic                resp_valid_q;

    logic                grant_found;
    logic [ID_W-1:0]     grant_id;
    logic [DATA_W-1:0]   grant_data;
    logic [NUM_REQ-1:0]  req_ready_c;

    // Search for the first asserted request starting at rr_ptr, wrapping
    // modulo NUM_REQ so the most recently served requester is looked at last.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    assign grant_data = bus.req_data[int'(grant_id)*DATA_W +: DATA_W];

    // Accept is combinational so the handshake completes in the IDLE cycle;
    // rst_n gates it so nothing is accepted while reset is held.
    always_comb begin
        req_ready_c = '0;
        if (rst_n && (state == IDLE) && grant_found) begin
            req_ready_c[grant_id] = 1'b1;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;

    // Sequencer: IDLE -> LOOKUP (LUT_LAT cycles) -> RESP -> IDLE.
    // cnt is loaded with LUT_LAT-1 so the last LOOKUP cycle is the one with
    // cnt==0, where lut_out is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            cnt          <= '0;
            lut_in       <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        lut_in    <= grant_data;
                        resp_id_q <= grant_id;
                        cnt       <= 4'(LUT_LAT - 1);
                        busy      <= 1'b1;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_data_q  <= lut_out;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy         <= 1'b0;
                        rr_ptr       <= (resp_id_q == ID_W'(NUM_REQ - 1)) ?
                                        '0 : resp_id_q + 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef LOG_LUT_ARBITER_STATS_EN
    // Saturating activity counters: completed responses and backpressure
    // cycles spent waiting in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_done  <= '0;
            stat_stall <= '0;
        end else begin
            if ((state == RESP) && resp_valid_q && bus.resp_ready &&
                (stat_done != 32'hFFFF_FFFF)) begin
                stat_done <= stat_done + 32'd1;
            end
            if ((state == RESP) && !bus.resp_ready &&
                (stat_stall != 32'hFFFF_FFFF)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_log_lut_arbiter.sv
// ----------------------------------------------------------------------------
// tb_log_lut_arbiter
// Self-checking bench for log_lut_arbiter. Two instances are used: one with
// LUT_LAT=1 for arbitration, backpressure and reset scenarios, and one with
// LUT_LAT=4 for the long settle path. A behavioural function stands in for
// log_lut. Expected responses are queued at grant time and popped when the
// DUT raises resp_valid.
// ----------------------------------------------------------------------------
module tb_log_lut_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    log_lut_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus  ();
    log_lut_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus4 ();

    logic [DW-1:0] lut_in, lut_out, lut_in4, lut_out4;
    logic          busy, busy4;
`ifdef LOG_LUT_ARBITER_STATS_EN
    logic [31:0]   stat_done, stat_stall, stat_done4, stat_stall4;
`endif

    // Stand-in for log_lut: any fixed, data-dependent mapping will do.
    function automatic logic [31:0] lut_model(input logic [31:0] x);
        return ({x[7:0], x[31:8]} ^ 32'h5A5A_1234) + 32'd7;
    endfunction

    assign lut_out  = lut_model(lut_in);
    assign lut_out4 = lut_model(lut_in4);

    log_lut_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LUT_LAT(1)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .lut_in  (lut_in),
        .lut_out (lut_out),
        .busy    (busy)
`ifdef LOG_LUT_ARBITER_STATS_EN
        ,
        .stat_done  (stat_done),
        .stat_stall (stat_stall)
`endif
    );

    log_lut_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LUT_LAT(4)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus4),
        .lut_in  (lut_in4),
        .lut_out (lut_out4),
        .busy    (busy4)
`ifdef LOG_LUT_ARBITER_STATS_EN
        ,
        .stat_done  (stat_done4),
        .stat_stall (stat_stall4)
`endif
    );

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          model_ptr = 0;
    int          n_done = 0;
    logic [31:0] req_d [NR];

    // Reference round-robin search.
    function automatic int exp_grant(input logic [3:0] mask, input int ptr);
        for (int i = 0; i < NR; i++) begin
            if (mask[(ptr + i) % NR]) return (ptr + i) % NR;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic [3:0] mask, input logic ready);
        bus.req_valid = mask;
        for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = req_d[i];
        bus.resp_ready = ready;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) req_d[i] = 32'h1111_1111 * (i + 1);
        applyStimulus(4'hF, 1'b1);
        bus4.req_valid  = '0;
        bus4.req_data   = '0;
        bus4.resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (lut_in !== 32'h0) begin errors++; $display("[TB] FAIL reset_lut_in: got %h expected 0", lut_in); end
        checks++; if (bus.resp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_resp_data: got %h expected 0", bus.resp_data); end
        checks++; if (bus.resp_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_resp_id: got %0d expected 0", bus.resp_id); end
        applyStimulus(4'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        n_done = 0;
    endtask

    task automatic test_single;
        int g;
        logic [3:0] oh;
        exp_t e;
        @(negedge clk);
        req_d[2] = 32'h3F80_0000;
        applyStimulus(4'b0100, 1'b1);
        #1;
        g  = exp_grant(4'b0100, model_ptr);
        oh = 4'b1 << g;
        checks++; if (bus.req_ready !== oh) begin errors++; $display("[TB] FAIL single_grant: got %b expected %b", bus.req_ready, oh); end
        sb.push_back('{id: 2'(g), data: lut_model(req_d[g])});
        @(negedge clk);
        applyStimulus(4'b0000, 1'b1);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
        checks++; if (lut_in !== 32'h3F80_0000) begin errors++; $display("[TB] FAIL single_lut_in: got %h expected 3f800000", lut_in); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid: got %b expected 0", bus.resp_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_latency: resp_valid got %b expected 1", bus.resp_valid); end
        e = sb.pop_front();
        checks++; if (bus.resp_id !== e.id) begin errors++; $display("[TB] FAIL single_id: got %0d expected %0d", bus.resp_id, e.id); end
        checks++; if (bus.resp_data !== e.data) begin errors++; $display("[TB] FAIL single_data: got %h expected %h", bus.resp_data, e.data); end
        model_ptr = (g + 1) % NR;
        n_done++;
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_release: resp_valid got %b expected 0", bus.resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: busy got %b expected 0", busy); end
    endtask

    // Streams n transactions with resp_ready high and the given request mask
    // held; checks grant order, issue interval and response contents.
    task automatic test_round_robin(input logic [3:0] mask, input int n, input string name);
        int w, g, lat, last;
        logic [3:0] oh;
        exp_t e;
        last = 0;
        for (int k = 0; k < n; k++) begin
            w = 0;
            @(negedge clk);
            applyStimulus(mask, 1'b1);
            #1;
            while (bus.req_ready === 4'b0 && w < 20) begin
                @(negedge clk);
                #1;
                w++;
            end
            if (w >= 20) begin
                checks++; errors++;
                $display("[TB] FAIL %s_grant_timeout: got no grant expected one within 20 cycles", name);
                applyStimulus(4'h0, 1'b1);
                return;
            end
            g  = exp_grant(mask, model_ptr);
            oh = 4'b1 << g;
            checks++; if (bus.req_ready !== oh) begin errors++; $display("[TB] FAIL %s_grant%0d: got %b expected %b", name, k, bus.req_ready, oh); end
            if (k > 0) begin
                checks++; if (cyc - last != 3) begin errors++; $display("[TB] FAIL %s_interval%0d: got %0d expected 3", name, k, cyc - last); end
            end
            last = cyc;
            sb.push_back('{id: 2'(g), data: lut_model(req_d[g])});
            @(negedge clk);
            req_d[g] = $urandom;
            applyStimulus(mask, 1'b1);
            #1;
            lat = 1;
            while (bus.resp_valid !== 1'b1 && lat < 20) begin
                @(negedge clk);
                #1;
                lat++;
            end
            checks++; if (lat != 2) begin errors++; $display("[TB] FAIL %s_latency%0d: got %0d expected 2", name, k, lat); end
            e = sb.pop_front();
            checks++; if (bus.resp_id !== e.id) begin errors++; $display("[TB] FAIL %s_id%0d: got %0d expected %0d", name, k, bus.resp_id, e.id); end
            checks++; if (bus.resp_data !== e.data) begin errors++; $display("[TB] FAIL %s_data%0d: got %h expected %h", name, k, bus.resp_data, e.data); end
            model_ptr = (g + 1) % NR;
            n_done++;
        end
        @(negedge clk);
        applyStimulus(4'h0, 1'b1);
    endtask

    task automatic test_backpressure;
        int g, lat;
        logic [3:0] oh;
        exp_t e;
        @(negedge clk);
        applyStimulus(4'hF, 1'b0);
        #1;
        g  = exp_grant(4'hF, model_ptr);
        oh = 4'b1 << g;
        checks++; if (bus.req_ready !== oh) begin errors++; $display("[TB] FAIL bp_grant: got %b expected %b", bus.req_ready, oh); end
        sb.push_back('{id: 2'(g), data: lut_model(req_d[g])});
        @(negedge clk);
        #1;
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        checks++; if (lat != 2) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected 2", lat); end
        e = sb.pop_front();
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== e.data || bus.resp_id !== e.id || bus.req_ready !== 4'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b data=%h id=%0d ready=%b expected valid=1 data=%h id=%0d ready=0000",
                         c, bus.resp_valid, bus.resp_data, bus.resp_id, bus.req_ready, e.data, e.id);
            end
        end
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.req_ready !== 4'b0) begin errors++; $display("[TB] FAIL bp_hold11: got valid=%b ready=%b expected valid=1 ready=0000", bus.resp_valid, bus.req_ready); end
        applyStimulus(4'h0, 1'b1);
        model_ptr = (g + 1) % NR;
        n_done++;
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: resp_valid got %b expected 0", bus.resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle: busy got %b expected 0", busy); end
`ifdef LOG_LUT_ARBITER_STATS_EN
        checks++; if (stat_stall !== 32'd10) begin errors++; $display("[TB] FAIL bp_stat_stall: got %0d expected 10", stat_stall); end
        checks++; if (stat_done !== 32'(n_done)) begin errors++; $display("[TB] FAIL bp_stat_done: got %0d expected %0d", stat_done, n_done); end
`endif
    endtask

    task automatic test_lut_lat4;
        int lat;
        logic [31:0] x;
        exp_t e;
        x = 32'hC0DE_1234;
        @(negedge clk);
        bus4.req_data        = '0;
        bus4.req_data[31:0]  = x;
        bus4.req_valid       = 4'b0001;
        bus4.resp_ready      = 1'b1;
        #1;
        checks++; if (bus4.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL lat4_grant: got %b expected 0001", bus4.req_ready); end
        sb.push_back('{id: 2'd0, data: lut_model(x)});
        @(negedge clk);
        bus4.req_valid = 4'b0000;
        bus4.req_data  = '0;
        #1;
        lat = 1;
        while (bus4.resp_valid !== 1'b1 && lat < 20) begin
            checks++; if (lut_in4 !== x) begin errors++; $display("[TB] FAIL lat4_lut_in_hold%0d: got %h expected %h", lat, lut_in4, x); end
            @(negedge clk);
            #1;
            lat++;
        end
        checks++; if (lat != 5) begin errors++; $display("[TB] FAIL lat4_latency: got %0d expected 5", lat); end
        e = sb.pop_front();
        checks++; if (bus4.resp_id !== e.id) begin errors++; $display("[TB] FAIL lat4_id: got %0d expected %0d", bus4.resp_id, e.id); end
        checks++; if (bus4.resp_data !== e.data) begin errors++; $display("[TB] FAIL lat4_data: got %h expected %h", bus4.resp_data, e.data); end
        @(negedge clk);
        #1;
        checks++; if (bus4.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL lat4_release: resp_valid got %b expected 0", bus4.resp_valid); end
    endtask

    task automatic test_reset_mid_lookup;
        int g, stale;
        logic [3:0] oh;
        @(negedge clk);
        req_d[1] = 32'hDEAD_BEEF;
        applyStimulus(4'b0010, 1'b1);
        #1;
        g  = exp_grant(4'b0010, model_ptr);
        oh = 4'b1 << g;
        checks++; if (bus.req_ready !== oh) begin errors++; $display("[TB] FAIL rst_mid_grant: got %b expected %b", bus.req_ready, oh); end
        @(negedge clk);
        applyStimulus(4'b0000, 1'b1);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_busy_before: got %b expected 1", busy); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_resp_valid: got %b expected 0", bus.resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (lut_in !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_lut_in: got %h expected 0", lut_in); end
        checks++; if (bus.resp_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_resp_data: got %h expected 0", bus.resp_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        n_done = 0;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (bus.resp_valid === 1'b1) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("[TB] FAIL rst_mid_stale_resp: got %0d valid cycles expected 0", stale); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_idle: busy got %b expected 0", busy); end
`ifdef LOG_LUT_ARBITER_STATS_EN
        checks++; if (stat_done !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_stat_done: got %0d expected 0", stat_done); end
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin(4'b1001, 2, "wrap");
        test_backpressure();
        test_lut_lat4();
        test_reset_mid_lookup();
        test_round_robin(4'b1111, 5, "round_robin");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/log_lut_arbiter.md
Name: log_lut_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational log_lut instance among NUM_REQ requesters. It accepts one operand at a time over a valid/ready handshake and drives the operand onto the LUT input. It waits a programmable number of cycles for the LUT output to settle, then returns the registered result with the requester ID over a valid/ready response channel. It sits between the approximate-kernel datapath lanes and the single shared log_lut.

Parameters:
NUM_REQ, 4, number of requesters; legal 2..8.
DATA_W, 32, operand/result width; matches log_lut d_in/d_out.
LUT_LAT, 1, settle cycles spent in LOOKUP before sampling lut_out; legal 1..15.
ID_W (localparam), clog2(NUM_REQ), requester ID width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand valid
req_data  in  NUM_REQ*DATA_W  operands; requester i at bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot grant/accept
resp_valid  out  1  result available
resp_ready  in  1  downstream accepts result
resp_data  out  DATA_W  registered LUT result
resp_id  out  ID_W  index of the requester that owns resp_data
lut_in  out  DATA_W  to log_lut d_in; registered
lut_out  in  DATA_W  from log_lut d_out
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync-safe deassert by the user): state=IDLE, rr_ptr=0, lut_in=0, resp_data=0, resp_id=0, resp_valid=0, busy=0, wait counter=0. req_ready is 0 whenever rst_n=0.
- FSM states: IDLE -> LOOKUP -> RESP -> IDLE.
- IDLE:
  - Grant goes to the first asserted req_valid, searching from index rr_ptr upward with modulo-NUM_REQ wrap.
  - req_ready[g]=1 combinationally, in IDLE only; at most one bit is set.
  - The handshake completes that cycle. On the edge: lut_in<=req_data[g], resp_id<=g, cnt<=LUT_LAT-1, state<=LOOKUP.
  - With no req_valid asserted, the block stays in IDLE and req_ready=0.
- LOOKUP:
  - req_ready=0; lut_in is held stable.
  - If cnt!=0, cnt decrements.
  - If cnt==0: resp_data<=lut_out, resp_valid<=1, state<=RESP.
  - LOOKUP lasts exactly LUT_LAT cycles.
- RESP:
  - resp_valid=1; resp_data and resp_id are held.
  - On resp_valid&&resp_ready: resp_valid<=0, rr_ptr<=(resp_id+1) mod NUM_REQ, state<=IDLE.
- Latency: from the accept edge to the first cycle of resp_valid is LUT_LAT+1 cycles. Minimum issue interval is LUT_LAT+2 cycles, when resp_ready is held high.
- Fairness: a requester that keeps req_valid high is served within NUM_REQ grants.
- Requesters must hold req_valid and req_data until req_ready. The block does not register req_data before the grant.
- req_valid dropping in the same cycle the grant is evaluated: that request is not granted, and arbitration re-evaluates on the next cycle.
- rr_ptr wrap: resp_id=NUM_REQ-1 sets rr_ptr to 0.
- Reset in LOOKUP or RESP: the transaction is dropped and the block returns to IDLE with all reset values. No response is emitted for the dropped transaction.
- Backpressure: resp_ready=0 holds the block in RESP indefinitely. No new grants are issued during that time.

Optional Feature:
- Macro: LOG_LUT_ARBITER_STATS_EN.
- Defined:
  - Adds output stat_done (32 bits), reset to 0. It increments on each resp_valid&&resp_ready handshake and saturates at 32'hFFFFFFFF.
  - Adds output stat_stall (32 bits), reset to 0. It increments on each cycle in RESP with resp_ready=0, also saturating.
- Undefined: neither port nor the counters exist, and all other behaviour is identical.

Test Plan:
- Single request: reset, then req_valid=4'b0100 with req_data[2]=32'h3F800000, resp_ready=1 -> req_ready=4'b0100 for one cycle. resp_valid rises 2 cycles later (LUT_LAT=1) with resp_id=2 and resp_data equal to the log_lut output for that operand. rr_ptr becomes 3.
- Round-robin: all four req_valid held high -> grant order 0,1,2,3,0; each grant is separated by 3 cycles with resp_ready=1.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_data/resp_id stable and req_ready=4'b0000 throughout. Handshake on cycle 11, then IDLE. With stats enabled, stat_stall=10.
- Wrap: rr_ptr=3 and req_valid=4'b1001 -> grant 3 first, then grant 0.
- LUT_LAT=4: single request -> lut_in held 4 cycles, resp_valid 5 cycles after the accept edge.
- Reset mid-LOOKUP: assert rst_n=0 one cycle after a grant -> resp_valid, busy, lut_in and resp_data read 0 immediately (asynchronous). After release, no stale response is produced.
